// File: rtl/ll_rd_resp_buffer.sv
// Credit-based read-response buffer for the linked-list RAM read path.
// Requests go straight to a fixed-latency RAM. Returning words are captured
// into a small FIFO and drained in request order on a valid/ready interface.
// A read is issued only while a FIFO slot is reserved for every outstanding
// word, so response backpressure can never overflow the FIFO.
module ll_rd_resp_buffer #(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned RAM_LATENCY = 2,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   // request side
   input  logic [ADDR_W-1:0]               req_addr_i,
   input  logic                            req_valid_i,
   output logic                            req_ready_o,
   // RAM side
   output logic [ADDR_W-1:0]               ram_rd_addr_o,
   output logic                            ram_rd_en_o,
   input  logic [DATA_W-1:0]               ram_rd_data_i,
   input  logic                            ram_rd_data_val_i,
   // response side
   output logic [DATA_W-1:0]               resp_data_o,
   output logic                            resp_valid_o,
   input  logic                            resp_ready_i,
   // status
   output logic [$clog2(FIFO_DEPTH+1)-1:0] used_o,
   output logic                            err_o
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);

   // Pointers wrap for free only when the depth is a power of two.
   if (RAM_LATENCY < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
      $error("ll_rd_resp_buffer: bad RAM_LATENCY or FIFO_DEPTH");
   end

   logic [CntW-1:0]   in_flight_q, in_flight_d;
   logic [CntW-1:0]   fifo_count_q, fifo_count_d;
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

   logic issue;
   logic capture;
   logic pop;
   logic [CntW-1:0] used;

   // Credits and handshakes; ready is derived from registered counts only.
   always_comb begin
      used          = in_flight_q + fifo_count_q;
      req_ready_o   = (used < DepthC);
      ram_rd_addr_o = req_addr_i;
      ram_rd_en_o   = req_valid_i & req_ready_o;
      resp_valid_o  = (fifo_count_q != '0);
      resp_data_o   = mem_q[rd_ptr_q];
      used_o        = used;
      err_o         = err_q;
      issue         = ram_rd_en_o;
      capture       = ram_rd_data_val_i & (in_flight_q != '0);
      pop           = resp_valid_o & resp_ready_i;
   end

   // Next-state for counters, pointers and the sticky error flag.
   always_comb begin
      in_flight_d  = in_flight_q;
      fifo_count_d = fifo_count_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      err_d        = err_q;

      case ({issue, capture})
         2'b10:   in_flight_d = in_flight_q + CntW'(1);
         2'b01:   in_flight_d = in_flight_q - CntW'(1);
         default: in_flight_d = in_flight_q;
      endcase

      case ({capture, pop})
         2'b10:   fifo_count_d = fifo_count_q + CntW'(1);
         2'b01:   fifo_count_d = fifo_count_q - CntW'(1);
         default: fifo_count_d = fifo_count_q;
      endcase

      if (capture) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      // A data strobe with nothing outstanding is dropped and flagged.
      if (ram_rd_data_val_i && (in_flight_q == '0)) begin
         err_d = 1'b1;
      end
   end

   // Control state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         in_flight_q  <= '0;
         fifo_count_q <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         err_q        <= 1'b0;
      end else begin
         in_flight_q  <= in_flight_d;
         fifo_count_q <= fifo_count_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         err_q        <= err_d;
      end
   end

   // FIFO storage; contents need no reset since reads are gated by the count.
   always_ff @(posedge clk_i) begin
      if (capture) begin
         mem_q[wr_ptr_q] <= ram_rd_data_i;
      end
   end

endmodule

// File: tb/tb_ll_rd_resp_buffer.sv
// Directed bench for ll_rd_resp_buffer with a RAM model (data = addr*3)
// followed by a latency delay stage sharing the same reset.
module tb_ll_rd_resp_buffer;

   localparam int unsigned AW    = 8;
   localparam int unsigned DW    = 32;
   localparam int unsigned LAT   = 2;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned UW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [AW-1:0] ram_rd_addr;
   logic          ram_rd_en;
   logic [DW-1:0] ram_rd_data;
   logic          ram_rd_data_val;
   logic [DW-1:0] resp_data;
   logic          resp_valid;
   logic          resp_ready = 1'b0;
   logic [UW-1:0] used;
   logic          err;
   logic          spur_val = 1'b0;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ll_rd_resp_buffer #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .RAM_LATENCY(LAT),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .req_addr_i       (req_addr),
      .req_valid_i      (req_valid),
      .req_ready_o      (req_ready),
      .ram_rd_addr_o    (ram_rd_addr),
      .ram_rd_en_o      (ram_rd_en),
      .ram_rd_data_i    (ram_rd_data),
      .ram_rd_data_val_i(ram_rd_data_val),
      .resp_data_o      (resp_data),
      .resp_valid_o     (resp_valid),
      .resp_ready_i     (resp_ready),
      .used_o           (used),
      .err_o            (err)
   );

   // RAM plus delay stage: strobe and data appear LAT cycles after the enable.
   logic [LAT-1:0] vpipe;
   logic [DW-1:0]  dpipe [LAT];
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         vpipe <= '0;
      end else begin
         vpipe[0] <= ram_rd_en;
         dpipe[0] <= DW'(ram_rd_addr) * DW'(3);
         for (int k = 1; k < LAT; k++) begin
            vpipe[k] <= vpipe[k-1];
            dpipe[k] <= dpipe[k-1];
         end
      end
   end
   assign ram_rd_data_val = vpipe[LAT-1] | spur_val;
   assign ram_rd_data     = spur_val ? 32'hDEAD_BEEF : dpipe[LAT-1];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic          rv;
      logic [AW-1:0] addr;
      logic          rr;
      logic          exp_rdy;
      logic          exp_vld;
      logic [DW-1:0] exp_data;
      logic [UW-1:0] exp_used;
   } vec_t;

   localparam int NVEC = 17;
   vec_t vecs [NVEC];

   int acc;
   int popped;
   int first_pop;
   int cyc;

   initial begin
      // single read 0x05, then 8 back-to-back reads 0..7 (one row per cycle)
      //          rv    addr   rr    rdy   vld   data   used
      vecs[0]  = '{1'b1, 8'h05, 1'b1, 1'b1, 1'b0, 32'h00, 3'd0};
      vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h00, 3'd1};
      vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h00, 3'd1};
      vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h0F, 3'd1};
      vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h00, 3'd0};
      vecs[5]  = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 32'h00, 3'd0};
      vecs[6]  = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 32'h00, 3'd1};
      vecs[7]  = '{1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 32'h00, 3'd2};
      vecs[8]  = '{1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 32'h00, 3'd3};
      vecs[9]  = '{1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 32'h03, 3'd3};
      vecs[10] = '{1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 32'h06, 3'd3};
      vecs[11] = '{1'b1, 8'h06, 1'b1, 1'b1, 1'b1, 32'h09, 3'd3};
      vecs[12] = '{1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 32'h0C, 3'd3};
      vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h0F, 3'd3};
      vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h12, 3'd2};
      vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h15, 3'd1};
      vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h00, 3'd0};

      // reset asserted between edges takes effect without a clock
      #2 rst = 1'b1;
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_used", 32'(used), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_rd_en", 32'(ram_rd_en), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // table-driven single read and streaming reads
      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         req_valid  = vecs[i].rv;
         req_addr   = vecs[i].addr;
         resp_ready = vecs[i].rr;
         #1;
         check($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].exp_rdy));
         check($sformatf("vec%0d_resp_valid", i), 32'(resp_valid), 32'(vecs[i].exp_vld));
         check($sformatf("vec%0d_used", i), 32'(used), 32'(vecs[i].exp_used));
         check($sformatf("vec%0d_rd_en", i), 32'(ram_rd_en), 32'(vecs[i].rv));
         if (vecs[i].exp_vld) begin
            check($sformatf("vec%0d_resp_data", i), resp_data, vecs[i].exp_data);
         end
      end

      // backpressure: offer 6 requests with resp_ready low
      acc = 0;
      resp_ready = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         req_valid = 1'b1;
         req_addr  = AW'(8'h10 + acc);
         #1;
         if (c >= 5 && resp_valid) begin
            check("stall_data_held", resp_data, 32'h30);
         end
         if (req_ready) acc++;
      end
      check("bp_accepted", 32'(acc), 32'd4);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_used", 32'(used), 32'd4);

      // drain, completing the remaining two requests
      popped    = 0;
      first_pop = -1;
      cyc       = 0;
      while (popped < 6 && cyc < 40) begin
         @(negedge clk);
         resp_ready = 1'b1;
         req_valid  = (acc < 6);
         req_addr   = AW'(8'h10 + acc);
         #1;
         if (first_pop >= 0 && cyc == first_pop + 1) begin
            check("credit_return_ready", 32'(req_ready), 32'd1);
         end
         if (resp_valid) begin
            if (first_pop < 0) begin
               first_pop = cyc;
               check("no_bypass_ready", 32'(req_ready), 32'd0);
            end
            check($sformatf("bp_resp%0d", popped), resp_data, (32'h10 + 32'(popped)) * 32'd3);
            popped++;
         end
         if (req_valid && req_ready) acc++;
         cyc++;
      end
      check("bp_all_popped", 32'(popped), 32'd6);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      check("bp_used_final", 32'(used), 32'd0);

      // spurious data strobe with nothing in flight
      @(negedge clk);
      spur_val = 1'b1;
      @(negedge clk);
      spur_val = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("spur%0d_err", c), 32'(err), 32'd1);
         check($sformatf("spur%0d_resp_valid", c), 32'(resp_valid), 32'd0);
         check($sformatf("spur%0d_used", c), 32'(used), 32'd0);
         @(negedge clk);
      end

      // reset with 2 reads in flight and 2 buffered
      resp_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         req_valid = 1'b1;
         req_addr  = AW'(8'h20 + c);
         @(negedge clk);
      end
      req_valid = 1'b0;
      #1;
      check("pre_rst_used", 32'(used), 32'd4);
      check("pre_rst_resp_valid", 32'(resp_valid), 32'd1);
      #1 rst = 1'b1;
      #1;
      check("mid_rst_req_ready", 32'(req_ready), 32'd1);
      check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
      check("mid_rst_used", 32'(used), 32'd0);
      check("mid_rst_err", 32'(err), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      resp_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         #1;
         check($sformatf("post_rst%0d_resp_valid", c), 32'(resp_valid), 32'd0);
         check($sformatf("post_rst%0d_used", c), 32'(used), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
